// File: rtl/sevenseg_scan3.sv
// Three-digit BCD scan driver for a common-anode 4-digit display.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits.
module sevenseg_scan3 #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SLOTS = 250
) (
  input  logic       CLK_I,
  input  logic       SW_RESET_I,
  input  logic [3:0] TIM_1,
  input  logic [3:0] TIM_2,
  input  logic [3:0] TIM_3,
  input  logic       TIMEOUT,
  output logic [6:0] SEG_O,
  output logic [3:0] AN_O,
  output logic       DP_O
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_SLOTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t        state;
  logic [CW-1:0] slot_cnt;
  logic [BW-1:0] blink_cnt;
  logic          hidden;
  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic          tick;
  logic [3:0]    digit;
  logic          dark;
  logic          lz_dark;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h3F;
    unique case (d)
      4'd0: s = 7'h40;
      4'd1: s = 7'h79;
      4'd2: s = 7'h24;
      4'd3: s = 7'h30;
      4'd4: s = 7'h19;
      4'd5: s = 7'h12;
      4'd6: s = 7'h02;
      4'd7: s = 7'h78;
      4'd8: s = 7'h00;
      4'd9: s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (slot_cnt == CW'(SCAN_DIV - 1));
  assign nidx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  assign DP_O = 1'b1;

  always_comb begin
    digit = TIM_1;
    unique case (nidx)
      2'd1:    digit = TIM_2;
      2'd2:    digit = TIM_3;
      default: digit = TIM_1;
    endcase
    if (TIMEOUT) digit = 4'd0;
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_dark = 1'b0;
    if (!TIMEOUT) begin
      if (nidx == 2'd2 && TIM_3 == 4'd0)
        lz_dark = 1'b1;
      if (nidx == 2'd1 && TIM_3 == 4'd0 && TIM_2 == 4'd0)
        lz_dark = 1'b1;
    end
  end
`else
  assign lz_dark = 1'b0;
`endif

  assign dark = lz_dark | (TIMEOUT & hidden);

  // Reset release is expected synchronous to CLK_I upstream.
  always_ff @(posedge CLK_I or posedge SW_RESET_I) begin
    if (SW_RESET_I) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      blink_cnt <= '0;
      hidden    <= 1'b0;
      idx       <= 2'd0;
      SEG_O     <= 7'h7F;
      AN_O      <= 4'hF;
    end else begin
      slot_cnt <= tick ? '0 : slot_cnt + CW'(1);

      if (!TIMEOUT) begin
        blink_cnt <= '0;
        hidden    <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BW'(BLINK_SLOTS - 1)) begin
          blink_cnt <= '0;
          hidden    <= ~hidden;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (tick) begin
        state <= BLANK;
        SEG_O <= 7'h7F;
        AN_O  <= 4'hF;
      end else if (state == BLANK) begin
        state <= DRIVE;
        idx   <= nidx;
        if (dark) begin
          SEG_O <= 7'h7F;
          AN_O  <= 4'hF;
        end else begin
          SEG_O <= decode(digit);
          AN_O  <= ~(4'b0001 << nidx);
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan3.sv
// Randomized bench for sevenseg_scan3 against a slot/time reference model.
// Build with +define+LEADING_ZERO_BLANK_EN to cover the blanking option.
module tb_sevenseg_scan3;

  localparam int SD = 4;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tim1, tim2, tim3;
  logic       tout;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // model: edges since reset, consecutive timeout ticks, expected outputs
  int         n;
  int         j;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;

  logic [6:0] dec [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  sevenseg_scan3 #(
    .SCAN_DIV   (SD),
    .BLINK_SLOTS(BS)
  ) dut (
    .CLK_I     (clk),
    .SW_RESET_I(rst),
    .TIM_1     (tim1),
    .TIM_2     (tim2),
    .TIM_3     (tim3),
    .TIMEOUT   (tout),
    .SEG_O     (seg),
    .AN_O      (an),
    .DP_O      (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    n = 0;
    j = 0;
    exp_seg = 7'h7F;
    exp_an = 4'hF;
  endtask

  // Compute the expected outputs after the coming edge from current inputs.
  task automatic model_edge();
    int         k;
    int         d;
    logic       drk;
    k = n % SD;
    if (k == SD - 1) begin
      exp_seg = 7'h7F;
      exp_an = 4'hF;
    end else if (k == 0 && n > 0) begin
      k = (n / SD) % 3;
      d = (k == 0) ? tim1 : (k == 1) ? tim2 : tim3;
      drk = 1'b0;
      if (tout) begin
        d = 0;
        drk = ((j / BS) % 2) == 1;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (!tout && k == 2 && tim3 == 0) drk = 1'b1;
      if (!tout && k == 1 && tim3 == 0 && tim2 == 0) drk = 1'b1;
`endif
      if (drk) begin
        exp_seg = 7'h7F;
        exp_an = 4'hF;
      end else begin
        exp_seg = dec[d];
        exp_an = 4'hF & ~(4'd1 << k);
      end
    end
    if (!tout) j = 0;
    else if ((n % SD) == SD - 1) j++;
    n++;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("an", {4'h0, an}, {4'h0, exp_an});
    check("an_one_low", {7'd0, $countones(~an) <= 1}, 8'd1);
    check("an3_off", {7'd0, an[3]}, 8'd1);
    check("dp_off", {7'd0, dp}, 8'd1);
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) cyc();
  endtask

  task automatic set_tim(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
    tim1 = a;
    tim2 = b;
    tim3 = c;
  endtask

  initial begin
    rst = 1'b1;
    tout = 1'b0;
    set_tim(4'd3, 4'd2, 4'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", {1'b0, seg}, 8'h7F);
    check("reset_an", {4'h0, an}, 8'h0F);
    check("reset_dp", {7'd0, dp}, 8'd1);
    @(negedge clk);
    rst = 1'b0;

    // directed opening sequence with literal expectations
    run(4);
    check("pre_drive_an", {4'h0, an}, 8'h0F);
    run(1);
    check("first_drive_an", {4'h0, an}, 8'h0D);
`ifndef LEADING_ZERO_BLANK_EN
    check("first_drive_seg", {1'b0, seg}, 8'h24);
    run(4);
    check("second_drive_an", {4'h0, an}, 8'h0B);
    check("second_drive_seg", {1'b0, seg}, 8'h40);
`else
    run(4);
`endif
    run(4);
    check("third_drive_an", {4'h0, an}, 8'h0E);
    check("third_drive_seg", {1'b0, seg}, 8'h30);
    run(20);

    set_tim(4'hC, 4'd2, 4'd0);
    run(16);

    set_tim(4'd5, 4'd1, 4'd0);
    tout = 1'b1;
    run(48);
    tout = 1'b0;
    run(16);

    set_tim(4'd7, 4'd0, 4'd0);
    run(16);
    set_tim(4'd7, 4'd2, 4'd0);
    run(16);

    // random inputs, occasional TIMEOUT toggles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_tim(4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 29) == 0) tout = ~tout;
      cyc();
    end

    // async reset in the middle of a DRIVE slot
    tout = 1'b0;
    set_tim(4'd3, 4'd2, 4'd0);
    run(14);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_seg", {1'b0, seg}, 8'h7F);
    check("async_rst_an", {4'h0, an}, 8'h0F);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
